// File: rtl/sqrt_pkg.sv
// Shared definitions for the non-restoring square-root controller.
// Build option: SQRT_REMAINDER_EN adds the remainder output.
package sqrt_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int ROOT_W        = DEFAULT_WIDTH / 2;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

endpackage

// File: rtl/sqrt_ctrl_if.sv
// Operand/result handshake bundle for sqrt_ctrl.
// Build option: SQRT_REMAINDER_EN adds the remainder signal and modport member.
interface sqrt_ctrl_if
    import sqrt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    localparam int N = WIDTH / 2;

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] radicand;
    logic             out_valid;
    logic             out_ready;
    logic [N-1:0]     root;
    logic             busy;
`ifdef SQRT_REMAINDER_EN
    logic [N:0]       remainder;

    modport master (
        output in_valid, radicand, out_ready,
        input  in_ready, out_valid, root, remainder, busy
    );
    modport slave (
        input  in_valid, radicand, out_ready,
        output in_ready, out_valid, root, remainder, busy
    );
`else
    modport master (
        output in_valid, radicand, out_ready,
        input  in_ready, out_valid, root, busy
    );
    modport slave (
        input  in_valid, radicand, out_ready,
        output in_ready, out_valid, root, busy
    );
`endif

endinterface

// File: rtl/sqrt_addsub.sv
// Ripple-carry adder/subtractor (sum = a + b, or a - b when sub is set)
// built from full_adder cells; the carry out of the sign bit is discarded.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);
    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));
endmodule

module sqrt_addsub #(
    parameter int W = 10
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    output logic [W-1:0] sum
);
    logic [W-1:0] b_x;
    logic [W-1:0] carry;

    // Two's-complement subtract: invert b and inject a carry of one.
    assign b_x      = b ^ {W{sub}};
    assign carry[0] = sub;

    for (genvar k = 0; k < W - 1; k++) begin : g_cell
        full_adder u_fa (
            .a   (a[k]),
            .b   (b_x[k]),
            .cin (carry[k]),
            .sum (sum[k]),
            .cout(carry[k+1])
        );
    end

    assign sum[W-1] = a[W-1] ^ b_x[W-1] ^ carry[W-1];
endmodule

// File: rtl/sqrt_ctrl.sv
// Iterative non-restoring square root, one root bit per cycle, one shared add/sub.
// Build option: SQRT_REMAINDER_EN exposes the final remainder.
module sqrt_ctrl
    import sqrt_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic       clk,
    input  logic       rst_n,
    sqrt_ctrl_if.slave bus
);
    localparam int N     = WIDTH / 2;
    localparam int RW    = N + 2;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
        $error("sqrt_ctrl: WIDTH must be even and at least 4");
    end

    state_t           state;
    state_t           state_next;
    logic [RW-1:0]    r;
    logic [N-1:0]     q;
    logic [WIDTH-1:0] rad;
    logic [CNT_W-1:0] cnt;

    logic [RW-1:0]    add_a;
    logic [RW-1:0]    add_b;
    logic [RW-1:0]    add_sum;
    logic             add_sub;
    logic             r_neg;

    assign r_neg = r[RW-1];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves a signal unassigned and infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (bus.in_valid)  state_next = S_ITER;
            S_ITER:  if (cnt == '0)     state_next = S_FIX;
            S_FIX:                      state_next = S_DONE;
            S_DONE:  if (bus.out_ready) state_next = S_IDLE;
            default:                    state_next = S_IDLE;
        endcase
    end

    // ITER feeds the shifted remainder with the next radicand pair; FIX reuses
    // the same adder to add back (Q<<1|1) when the last step went negative.
    always_comb begin
        add_a   = {r[N-1:0], rad[WIDTH-1 -: 2]};
        add_b   = {q, r_neg ? 2'b11 : 2'b01};
        add_sub = ~r_neg;
        if (state == S_FIX) begin
            add_a   = r;
            add_b   = {1'b0, q, 1'b1};
            add_sub = 1'b0;
        end
    end

    sqrt_addsub #(.W(RW)) u_addsub (
        .a  (add_a),
        .b  (add_b),
        .sub(add_sub),
        .sum(add_sum)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r   <= '0;
            q   <= '0;
            rad <= '0;
            cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        rad <= bus.radicand;
                        r   <= '0;
                        q   <= '0;
                        cnt <= CNT_W'(N - 1);
                    end
                end
                S_ITER: begin
                    r   <= add_sum;
                    q   <= {q[N-2:0], ~add_sum[RW-1]};
                    rad <= rad << 2;
                    cnt <= cnt - 1'b1;
                end
                S_FIX: begin
                    if (r_neg) r <= add_sum;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = (state == S_IDLE);
    assign bus.out_valid = (state == S_DONE);
    assign bus.busy      = (state == S_ITER) || (state == S_FIX);
    assign bus.root      = q;
`ifdef SQRT_REMAINDER_EN
    assign bus.remainder = r[N:0];
`endif

endmodule
